// File: rtl/ir_fetch.sv
// Instruction-fetch responder: fetches a word at pc_addr over req/ack, holds it in
// the instruction register for a valid/ready consumer, then steps or loads the PC.
module ir_fetch #(
    parameter int unsigned AW     = 13,
    parameter int unsigned DW     = 16,
    parameter logic [2:0]  OP_HLT = 3'b000,
    parameter logic [2:0]  OP_JZ  = 3'b110,
    parameter logic [2:0]  OP_JMP = 3'b111
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          zero_flag,
    output logic          load,
    output logic [AW-1:0] ir_addr,
    output logic          pc_step,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_STEP,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_mem_req;
    logic [DW-1:0] r_ir;
    logic          r_ir_valid;
    logic          r_load;
    logic          r_pc_step;
    logic [AW-1:0] r_ir_addr;
    logic          r_halted;

    logic          w_mem_req_nxt;
    logic [DW-1:0] w_ir_nxt;
    logic          w_ir_valid_nxt;
    logic          w_load_nxt;
    logic          w_pc_step_nxt;
    logic [AW-1:0] w_ir_addr_nxt;
    logic          w_halted_nxt;

    logic [2:0]    w_opcode;
    logic          w_fetch_done;
    logic          w_issue_done;
    logic          w_take_jump;

    assign w_opcode     = r_ir[DW-1:DW-3];
    // An ack only counts while a request is actually outstanding.
    assign w_fetch_done = (r_state == S_FETCH) && r_mem_req && mem_ack;
    assign w_issue_done = (r_state == S_ISSUE) && ir_ready;
    assign w_take_jump  = (w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && zero_flag);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_load     <= 1'b0;
            r_pc_step  <= 1'b0;
            r_ir_addr  <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_load     <= w_load_nxt;
            r_pc_step  <= w_pc_step_nxt;
            r_ir_addr  <= w_ir_addr_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FETCH: if (w_fetch_done) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_issue_done) w_state_nxt = S_STEP;
            S_STEP:  w_state_nxt = (w_opcode == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Strobes default low so each lasts exactly one cycle; everything else holds.
    always_comb begin
        w_mem_req_nxt  = r_mem_req;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = r_ir_valid;
        w_load_nxt     = 1'b0;
        w_pc_step_nxt  = 1'b0;
        w_ir_addr_nxt  = r_ir_addr;
        w_halted_nxt   = r_halted;
        unique case (r_state)
            S_FETCH: begin
                if (w_fetch_done) begin
                    w_ir_nxt       = mem_data;
                    w_mem_req_nxt  = 1'b0;
                    w_ir_valid_nxt = 1'b1;
                end else begin
                    w_mem_req_nxt  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_issue_done) begin
                    w_ir_valid_nxt = 1'b0;
                    if (w_opcode != OP_HLT) begin
                        if (w_take_jump) begin
                            w_load_nxt    = 1'b1;
                            w_ir_addr_nxt = r_ir[AW-1:0];
                        end else begin
                            w_pc_step_nxt = 1'b1;
                        end
                    end
                end
            end
            S_STEP: begin
                if (w_opcode == OP_HLT) begin
                    w_halted_nxt  = 1'b1;
                end else begin
                    w_mem_req_nxt = 1'b1;
                end
            end
            S_HALT: begin
                w_mem_req_nxt = 1'b0;
            end
            default: begin
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign mem_addr = pc_addr;
    assign mem_req  = r_mem_req;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign load     = r_load;
    assign pc_step  = r_pc_step;
    assign ir_addr  = r_ir_addr;
    assign halted   = r_halted;

endmodule
